// File: rtl/not_gate_tester.sv
// ============================================================================
// Module      : not_gate_tester
// Description : Go/no-go tester for an external inverter. Applies alternating
//               0/1 vectors, waits for settling, samples the response and
//               reports mismatch count, first failing vector and pass/fail.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module not_gate_tester #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ROUNDS        = 8,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             dut_a,
    input  logic             dut_z,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [7:0]       first_fail
);

    localparam logic [2:0]       c_st_idle   = 3'd0;
    localparam logic [2:0]       c_st_drive  = 3'd1;
    localparam logic [2:0]       c_st_settle = 3'd2;
    localparam logic [2:0]       c_st_sample = 3'd3;
    localparam logic [2:0]       c_st_done   = 3'd4;

    localparam logic [7:0]       c_last_v    = 8'(2 * ROUNDS - 1);
    localparam logic [7:0]       c_settle    = 8'(SETTLE_CYCLES);
    localparam logic [7:0]       c_none      = 8'hFF;
    localparam logic [CNT_W-1:0] c_err_max   = '1;

    typedef enum logic [2:0] {
        st_idle   = c_st_idle,
        st_drive  = c_st_drive,
        st_settle = c_st_settle,
        st_sample = c_st_sample,
        st_done   = c_st_done
    } state_t;

    state_t           r_state;
    logic [7:0]       r_v;
    logic [7:0]       r_settle;
    logic             r_dut_a;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [CNT_W-1:0] r_err;
    logic [7:0]       r_first_fail;

    state_t           w_state_next;
    logic [7:0]       w_v_next;
    logic [7:0]       w_settle_next;
    logic             w_dut_a_next;
    logic             w_busy_next;
    logic             w_done_next;
    logic             w_pass_next;
    logic [CNT_W-1:0] w_err_next;
    logic [7:0]       w_first_fail_next;
    logic             w_mismatch;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= st_idle;
            r_v          <= 8'd0;
            r_settle     <= 8'd0;
            r_dut_a      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err        <= '0;
            r_first_fail <= c_none;
        end else begin
            r_state      <= w_state_next;
            r_v          <= w_v_next;
            r_settle     <= w_settle_next;
            r_dut_a      <= w_dut_a_next;
            r_busy       <= w_busy_next;
            r_done       <= w_done_next;
            r_pass       <= w_pass_next;
            r_err        <= w_err_next;
            r_first_fail <= w_first_fail_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_v_next          = r_v;
        w_settle_next     = r_settle;
        w_dut_a_next      = r_dut_a;
        w_done_next       = 1'b0;
        w_pass_next       = r_pass;
        w_err_next        = r_err;
        w_first_fail_next = r_first_fail;
        // A good inverter drives the complement of what we present.
        w_mismatch        = (dut_z == r_dut_a);

        case (r_state)
            st_idle: begin
                if (start) begin
                    w_state_next      = st_drive;
                    w_v_next          = 8'd0;
                    w_dut_a_next      = 1'b0;
                    w_err_next        = '0;
                    w_first_fail_next = c_none;
                    w_pass_next       = 1'b0;
                end
            end
            st_drive: begin
                w_settle_next = c_settle;
                w_state_next  = (c_settle == 8'd0) ? st_sample : st_settle;
            end
            st_settle: begin
                if (r_settle <= 8'd1) begin
                    w_state_next = st_sample;
                end else begin
                    w_settle_next = r_settle - 8'd1;
                end
            end
            st_sample: begin
                if (w_mismatch) begin
                    if (r_err != c_err_max) begin
                        w_err_next = r_err + 1'b1;
                    end
                    if (r_first_fail == c_none) begin
                        w_first_fail_next = r_v;
                    end
                end
                // Pass is resolved on entry to DONE so it is valid alongside done.
                if (r_v == c_last_v) begin
                    w_state_next = st_done;
                    w_dut_a_next = 1'b0;
                    w_done_next  = 1'b1;
                    w_pass_next  = (w_err_next == '0);
                end else begin
                    w_state_next = st_drive;
                    w_v_next     = r_v + 8'd1;
                    w_dut_a_next = ~r_v[0];
                end
            end
            st_done: begin
                w_state_next = st_idle;
            end
            default: begin
                w_state_next = st_idle;
            end
        endcase

        w_busy_next = (w_state_next != st_idle);
    end

    assign dut_a      = r_dut_a;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_count  = r_err;
    assign first_fail = r_first_fail;

endmodule

`default_nettype wire

// File: tb/tb_not_gate_tester.sv
// ============================================================================
// Module      : tb_not_gate_tester
// Description : Three tester instances (default, zero settle, 3-bit counter)
//               run against modelled faulty/good inverters and a vector model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_not_gate_tester;

    localparam int c_rounds = 8;
    localparam int c_nvec   = 2 * c_rounds;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        launch;
    int          mode;
    logic [15:0] mask;
    int          j = 1000;

    logic [2:0]  dut_a;
    logic [2:0]  dut_z;
    logic [2:0]  busy;
    logic [2:0]  done;
    logic [2:0]  pass;
    logic [7:0]  err0;
    logic [7:0]  err1;
    logic [2:0]  err2;
    logic [7:0]  err_v [3];
    logic [7:0]  ff_v  [3];
    logic [2:0]  d1;
    logic [2:0]  d2;

    int          done_cnt [3] = '{0, 0, 0};
    int          done_j   [3] = '{0, 0, 0};
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    function automatic int s_of(input int g);
        return (g == 1) ? 0 : 2;
    endfunction

    function automatic int w_of(input int g);
        return (g == 2) ? 3 : 8;
    endfunction

    assign err_v[0] = err0;
    assign err_v[1] = err1;
    assign err_v[2] = {5'd0, err2};

    not_gate_tester #(.SETTLE_CYCLES(2), .ROUNDS(c_rounds), .CNT_W(8)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .dut_a(dut_a[0]), .dut_z(dut_z[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(err0),
        .first_fail(ff_v[0]));

    not_gate_tester #(.SETTLE_CYCLES(0), .ROUNDS(c_rounds), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .dut_a(dut_a[1]), .dut_z(dut_z[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(err1),
        .first_fail(ff_v[1]));

    not_gate_tester #(.SETTLE_CYCLES(2), .ROUNDS(c_rounds), .CNT_W(3)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .dut_a(dut_a[2]), .dut_z(dut_z[2]),
        .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_count(err2),
        .first_fail(ff_v[2]));

    // j counts cycles since the accepted start edge: cycle k+1 is j == 0.
    always @(posedge clk) begin
        if (launch) j <= 0;
        else        j <= j + 1;
    end

    always @(posedge clk) begin
        if (rst) begin
            d1 <= 3'b000;
            d2 <= 3'b000;
        end else begin
            d1 <= dut_a;
            d2 <= d1;
        end
    end

    // Inverter models: 0 good, 1 stuck-0, 2 stuck-1, 3 two-register delay, 4 per-vector flip mask
    for (genvar g = 0; g < 3; g++) begin : g_inv
        logic [31:0] idx;
        logic        flip;
        assign idx  = 32'(j / (s_of(g) + 2));
        assign flip = (idx < 32'd16) ? mask[idx[3:0]] : 1'b0;
        assign dut_z[g] = (mode == 1) ? 1'b0 :
                          (mode == 2) ? 1'b1 :
                          (mode == 3) ? ~d2[g] :
                          (mode == 4) ? (~dut_a[g] ^ flip) : ~dut_a[g];
    end

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (done[g]) begin
                done_cnt[g] <= done_cnt[g] + 1;
                done_j[g]   <= j;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Vector-level reference: vector v presents a = v mod 2, a good inverter answers 1 - a.
    function automatic void model(input int m, input logic [15:0] msk, input int s, input int w,
                                  output int e, output int ff, output int p);
        int a;
        int a_seen;
        int z;
        e  = 0;
        ff = 255;
        for (int v = 0; v < c_nvec; v++) begin
            a = v % 2;
            case (m)
                1: z = 0;
                2: z = 1;
                3: begin
                    a_seen = (s > 0) ? a : ((v == 0) ? 0 : (v - 1) % 2);
                    z = 1 - a_seen;
                end
                4: z = (1 - a) ^ int'(msk[v]);
                default: z = 1 - a;
            endcase
            if (z != 1 - a) begin
                if (e < (1 << w) - 1) e++;
                if (ff == 255) ff = v;
            end
        end
        p = (e == 0) ? 1 : 0;
    endfunction

    task automatic chk_idle_reset(input string pfx);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("%s_d%0d_busy", pfx, g),  32'(busy[g]),  32'd0);
            chk($sformatf("%s_d%0d_done", pfx, g),  32'(done[g]),  32'd0);
            chk($sformatf("%s_d%0d_pass", pfx, g),  32'(pass[g]),  32'd0);
            chk($sformatf("%s_d%0d_err", pfx, g),   32'(err_v[g]), 32'd0);
            chk($sformatf("%s_d%0d_ff", pfx, g),    32'(ff_v[g]),  32'd255);
            chk($sformatf("%s_d%0d_a", pfx, g),     32'(dut_a[g]), 32'd0);
        end
    endtask

    task automatic do_run(input string nm, input int m, input logic [15:0] msk,
                          input bit repulse, input bit abort);
        int base [3];
        int e;
        int ff;
        int p;
        mode = m;
        mask = msk;
        for (int g = 0; g < 3; g++) base[g] = done_cnt[g];
        start  = 1'b1;
        launch = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        launch = 1'b0;
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("%s_d%0d_busy_k1", nm, g), 32'(busy[g]),  32'd1);
            chk($sformatf("%s_d%0d_done_k1", nm, g), 32'(done[g]),  32'd0);
            chk($sformatf("%s_d%0d_err_k1", nm, g),  32'(err_v[g]), 32'd0);
            chk($sformatf("%s_d%0d_ff_k1", nm, g),   32'(ff_v[g]),  32'd255);
            chk($sformatf("%s_d%0d_pass_k1", nm, g), 32'(pass[g]),  32'd0);
        end
        for (int n = 1; n <= 70; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (repulse && (n == 10 || n == 32)) start = 1'b1;
            if (abort && n == 19) begin
                rst   = 1'b1;
                start = 1'b1;
            end
            if (abort && n == 20) begin
                chk_idle_reset({nm, "_rst"});
                rst = 1'b0;
            end
        end
        for (int g = 0; g < 3; g++) begin
            if (abort) begin
                chk($sformatf("%s_d%0d_ndone", nm, g), 32'(done_cnt[g] - base[g]), 32'd0);
                chk($sformatf("%s_d%0d_busy", nm, g),  32'(busy[g]),  32'd0);
                chk($sformatf("%s_d%0d_err", nm, g),   32'(err_v[g]), 32'd0);
                chk($sformatf("%s_d%0d_ff", nm, g),    32'(ff_v[g]),  32'd255);
            end else begin
                model(m, msk, s_of(g), w_of(g), e, ff, p);
                chk($sformatf("%s_d%0d_ndone", nm, g), 32'(done_cnt[g] - base[g]), 32'd1);
                chk($sformatf("%s_d%0d_tdone", nm, g), 32'(done_j[g]),
                    32'(c_nvec * (s_of(g) + 2)));
                chk($sformatf("%s_d%0d_err", nm, g),   32'(err_v[g]), 32'(e));
                chk($sformatf("%s_d%0d_ff", nm, g),    32'(ff_v[g]),  32'(ff));
                chk($sformatf("%s_d%0d_pass", nm, g),  32'(pass[g]),  32'(p));
                chk($sformatf("%s_d%0d_busy", nm, g),  32'(busy[g]),  32'd0);
                chk($sformatf("%s_d%0d_a", nm, g),     32'(dut_a[g]), 32'd0);
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b1;
        launch = 1'b0;
        mode   = 0;
        mask   = 16'h0000;
        repeat (3) @(negedge clk);
        chk_idle_reset("reset");
        rst   = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);

        do_run("good",   0, 16'h0000, 1'b0, 1'b0);
        do_run("stuck0", 1, 16'h0000, 1'b0, 1'b0);
        do_run("stuck1", 2, 16'h0000, 1'b0, 1'b0);
        do_run("delay",  3, 16'h0000, 1'b0, 1'b0);
        for (int r = 0; r < 6; r++) begin
            logic [15:0] m;
            m = (r % 2 == 0) ? 16'($urandom) : 16'($urandom & $urandom & $urandom);
            do_run($sformatf("rand%0d", r), 4, m, 1'b0, 1'b0);
        end
        do_run("repulse", 0, 16'h0000, 1'b1, 1'b0);
        do_run("abort",   0, 16'h0000, 1'b0, 1'b1);
        do_run("fail1",   1, 16'h0000, 1'b0, 1'b0);
        do_run("rerun",   4, 16'h8000, 1'b0, 1'b0);
        do_run("clean",   0, 16'h0000, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/not_gate_tester.md
NOT_GATE_TESTER -- requirements
Module: not_gate_tester

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, wait cycles between driving dut_a and sampling dut_z; legal range 0..255.
REQ-002 Parameter ROUNDS, default 8, test rounds per run; each round is two vectors (A=0, then A=1); legal range 1..127.
REQ-003 Parameter CNT_W, default 8, width of err_count; legal range 1..16.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  run request; sampled only in IDLE.
REQ-007 dut_a  output  1  stimulus driven to the inverter-under-test input A.
REQ-008 dut_z  input  1  inverter-under-test output Z.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse at end of run.
REQ-011 pass  output  1  run result; 1 iff err_count==0 at end of run.
REQ-012 err_count  output  CNT_W  mismatch count of current/last run, saturating.
REQ-013 first_fail  output  8  index of first mismatching vector; 8'hFF = none.

Function
REQ-014 FSM states IDLE, DRIVE, SETTLE, SAMPLE, DONE; all outputs registered.
REQ-015 IDLE: start=1 -> DRIVE next cycle; clears err_count to 0 and first_fail to 8'hFF and pass to 0; vector index v=0.
REQ-016 DRIVE: exactly 1 cycle; dut_a = v[0] (even v -> 0, odd v -> 1); loads settle counter with SETTLE_CYCLES; next SETTLE, or SAMPLE if SETTLE_CYCLES==0.
REQ-017 SETTLE: exactly SETTLE_CYCLES cycles, then SAMPLE.
REQ-018 SAMPLE: exactly 1 cycle; mismatch when dut_z != ~dut_a.
REQ-019 On mismatch: err_count increments, saturating at 2^CNT_W-1; first_fail <= v only if first_fail==8'hFF.
REQ-020 After SAMPLE: v==2*ROUNDS-1 -> DONE; else v<=v+1, -> DRIVE.
REQ-021 dut_a constant from DRIVE through SAMPLE of a vector; 0 in IDLE and DONE.
REQ-022 DONE: 1 cycle; done=1; pass <= (err_count==0, including the final SAMPLE's update); -> IDLE.
REQ-023 Latency: start sampled at edge k -> done high in cycle k+1+2*ROUNDS*(SETTLE_CYCLES+2).
REQ-024 start while busy (including DONE) is ignored; no queuing.
REQ-025 pass, err_count, first_fail hold their values in IDLE until the next accepted start.
REQ-026 err_count saturation does not stop the run; all vectors are still applied.

Reset
REQ-027 rst=1 at any edge forces IDLE, dut_a=0, busy=0, done=0, pass=0, err_count=0, first_fail=8'hFF, v=0, settle counter=0.
REQ-028 Reset mid-run aborts with no done pulse; start asserted in the same cycle as rst is ignored.
REQ-029 rst has priority over all other inputs.

Verification
REQ-030 Defaults, combinational good inverter (dut_z=~dut_a), start pulse at edge k -> busy from k+1, done only at cycle k+65, pass=1, err_count=0, first_fail=8'hFF.
REQ-031 Defaults, dut_z stuck at 0 -> done at k+65, err_count=8, first_fail=0, pass=0; stuck at 1 -> err_count=8, first_fail=1, pass=0.
REQ-032 DUT modelled as two-register delay (dut_z=~dut_a two cycles earlier, chain reset to match a=0), SETTLE_CYCLES=0 -> err_count=15, first_fail=1, pass=0; same model with SETTLE_CYCLES=2 -> pass=1.
REQ-033 CNT_W=3, dut_z stuck at 0 -> err_count saturates at 7, run still completes at k+65, pass=0.
REQ-034 start re-pulsed mid-run -> no restart, single done at k+65; rst at cycle k+20 -> next cycle all outputs at reset values, no done ever emitted for that run.
REQ-035 Second run after a failed run -> err_count and first_fail cleared on start, result reflects only the second run.
